sensor_conditioner: RTL and testbench

Vehicle-sensor front end for the intersection controller. Takes the three raw loop/presence inputs (Norton-north, Norton-south, Thevenin), synchronises and debounces them, and bridges short gaps between consecutive vehicles with a hold time. Also flags a sensor stuck active. Sits directly upstream of `fsm`: its `present` bits drive `SNN`/`SNS`/`STH`, and it runs on the same 10 kHz clock.

---
 rtl/tl_pkg.sv | 27 ++
 rtl/sensor_channel.sv | 124 ++++++++++++
 rtl/sensor_conditioner.sv | 42 ++++
 tb/tb_sensor_conditioner.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
// Shared intersection-controller definitions: sensor channel indices,
// channel state encoding and default cycle counts at the 10 kHz system clock.
package tl_pkg;

    localparam int SENS_NN = 0;
    localparam int SENS_NS = 1;
    localparam int SENS_TH = 2;

    localparam int N_SENS_DEF       = 3;
    localparam int DEB_CYCLES_DEF   = 200;      // 20 ms
    localparam int HOLD_CYCLES_DEF  = 20000;    // 2 s
    localparam int STUCK_CYCLES_DEF = 1200000;  // 120 s

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUAL    = 2'd1,
        PRESENT = 2'd2,
        HOLD    = 2'd3
    } ch_state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/sensor_channel.sv
// One sensor channel: two-flop synchroniser, debounce/hold state machine,
// and a stuck-active detector.
module sensor_channel
    import tl_pkg::*;
#(
    parameter int DEB_CYCLES   = DEB_CYCLES_DEF,
    parameter int HOLD_CYCLES  = HOLD_CYCLES_DEF,
    parameter int STUCK_CYCLES = STUCK_CYCLES_DEF
) (
    input  logic      clk,
    input  logic      reset_n,
    input  logic      enable,
    input  logic      raw,
    output logic      present,
    output logic      arrive,
    output logic      stuck,
    output ch_state_t state
);

    localparam int SW = $clog2(STUCK_CYCLES + 1);

    // The sample that moves IDLE to QUAL is the first qualifying high sample,
    // so the shared counter holds "high samples seen beyond the first".
    localparam logic [CNT_W-1:0] QUAL_LAST =
        (DEB_CYCLES >= 2) ? CNT_W'(DEB_CYCLES - 2) : '0;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [SW-1:0]    STUCK_LIM = SW'(STUCK_CYCLES);

    logic [1:0]       sync;
    logic             s;
    ch_state_t        state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [SW-1:0]    stuck_cnt, stuck_cnt_n;
    logic             arrive_n;

    assign s = sync[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync      <= '0;
            state     <= IDLE;
            cnt       <= '0;
            stuck_cnt <= '0;
            arrive    <= 1'b0;
        end else begin
            sync      <= {sync[0], raw};
            state     <= state_n;
            cnt       <= cnt_n;
            stuck_cnt <= stuck_cnt_n;
            arrive    <= arrive_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        stuck_cnt_n = stuck_cnt;
        arrive_n    = 1'b0;
        if (!enable) begin
            state_n     = IDLE;
            cnt_n       = '0;
            stuck_cnt_n = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (s) begin
                        cnt_n       = '0;
                        stuck_cnt_n = '0;
                        if (DEB_CYCLES <= 1) begin
                            state_n  = PRESENT;
                            arrive_n = 1'b1;
                        end else begin
                            state_n = QUAL;
                        end
                    end
                end
                QUAL: begin
                    if (!s) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else if (cnt >= QUAL_LAST) begin
                        state_n  = PRESENT;
                        arrive_n = 1'b1;
                        cnt_n    = '0;
                    end else begin
                        cnt_n = sat_inc(cnt);
                    end
                end
                PRESENT: begin
                    if (!s) begin
                        state_n     = HOLD;
                        cnt_n       = '0;
                        stuck_cnt_n = '0;
                    end else if (stuck_cnt != STUCK_LIM) begin
                        stuck_cnt_n = stuck_cnt + SW'(1);
                    end
                end
                HOLD: begin
                    // Any high sample resumes presence without a new arrival.
                    if (s) begin
                        state_n = PRESENT;
                        cnt_n   = '0;
                    end else if (cnt >= HOLD_LAST) begin
                        state_n     = IDLE;
                        cnt_n       = '0;
                        stuck_cnt_n = '0;
                    end else begin
                        cnt_n = sat_inc(cnt);
                    end
                end
                default: begin
                    state_n     = IDLE;
                    cnt_n       = '0;
                    stuck_cnt_n = '0;
                end
            endcase
        end
    end

    assign present = (state == PRESENT) || (state == HOLD);
    // The stuck counter is non-zero only in PRESENT, so saturation is the flag.
    assign stuck   = (stuck_cnt == STUCK_LIM);

endmodule

// File: rtl/sensor_conditioner.sv
// Vehicle-sensor front end: N_SENS independent conditioned channels feeding fsm.
// ch_state exposes each channel's state, two bits per channel.
module sensor_conditioner
    import tl_pkg::*;
#(
    parameter int N_SENS       = N_SENS_DEF,
    parameter int DEB_CYCLES   = DEB_CYCLES_DEF,
    parameter int HOLD_CYCLES  = HOLD_CYCLES_DEF,
    parameter int STUCK_CYCLES = STUCK_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [N_SENS-1:0]   raw,
    output logic [N_SENS-1:0]   present,
    output logic [N_SENS-1:0]   arrive,
    output logic [N_SENS-1:0]   stuck,
    output logic [2*N_SENS-1:0] ch_state
);

    for (genvar i = 0; i < N_SENS; i++) begin : g_ch
        ch_state_t st;

        sensor_channel #(
            .DEB_CYCLES  (DEB_CYCLES),
            .HOLD_CYCLES (HOLD_CYCLES),
            .STUCK_CYCLES(STUCK_CYCLES)
        ) u_ch (
            .clk    (clk),
            .reset_n(reset_n),
            .enable (enable),
            .raw    (raw[i]),
            .present(present[i]),
            .arrive (arrive[i]),
            .stuck  (stuck[i]),
            .state  (st)
        );

        assign ch_state[2*i +: 2] = st;
    end

endmodule

// File: tb/tb_sensor_conditioner.sv
// Bench for sensor_conditioner: reset and async-reset sequences, a segment
// table of directed patterns, and randomised traffic against a run-length model.
module tb_sensor_conditioner;
    import tl_pkg::*;

    localparam int DEB   = 4;
    localparam int HOLD  = 10;
    localparam int STUCK = 50;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0;
    logic [2:0] raw = 3'b000;
    logic [2:0] present, arrive, stuck;
    logic [5:0] ch_state;
    logic [5:0] idle_all;

    int n_cmp = 0;
    int n_bad = 0;

    sensor_conditioner #(
        .N_SENS      (3),
        .DEB_CYCLES  (DEB),
        .HOLD_CYCLES (HOLD),
        .STUCK_CYCLES(STUCK)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .raw     (raw),
        .present (present),
        .arrive  (arrive),
        .stuck   (stuck),
        .ch_state(ch_state)
    );

    always #50 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: sensor seen two samples late; presence from run lengths.
    logic [2:0] m_r1, m_r2, m_pres, m_stk, m_arr;
    int m_hi[3], m_lo[3], m_since[3];

    task automatic model_clear(input bit with_sync);
        m_pres = '0;
        m_stk  = '0;
        m_arr  = '0;
        for (int i = 0; i < 3; i++) begin
            m_hi[i] = 0;
            m_lo[i] = 0;
            m_since[i] = 0;
        end
        if (with_sync) begin
            m_r1 = '0;
            m_r2 = '0;
        end
    endtask

    task automatic model_step();
        logic s;
        bit   was_hold;
        if (!reset_n) begin
            model_clear(1'b1);
            return;
        end
        for (int i = 0; i < 3; i++) begin
            s = m_r2[i];
            m_r2[i] = m_r1[i];
            m_r1[i] = raw[i];
            m_arr[i] = 1'b0;
            if (!enable) begin
                m_pres[i] = 1'b0;
                m_stk[i] = 1'b0;
                m_hi[i] = 0;
                m_lo[i] = 0;
                m_since[i] = 0;
                continue;
            end
            was_hold = m_pres[i] && (m_lo[i] > 0);
            if (s) begin
                m_hi[i]++;
                m_lo[i] = 0;
            end else begin
                m_lo[i]++;
                m_hi[i] = 0;
            end
            if (!m_pres[i]) begin
                if (m_hi[i] >= DEB) begin
                    m_pres[i] = 1'b1;
                    m_arr[i] = 1'b1;
                    m_since[i] = 0;
                end
            end else if (s) begin
                m_since[i] = was_hold ? 0 : m_since[i] + 1;
                m_stk[i] = (m_since[i] >= STUCK);
            end else begin
                m_stk[i] = 1'b0;
                if (m_lo[i] >= HOLD + 1) m_pres[i] = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("model_present", present, m_pres);
        check("model_arrive", arrive, m_arr);
        check("model_stuck", stuck, m_stk);
    endtask

    typedef struct {
        logic [2:0] raw;
        logic       en;
        int         cycles;
        logic       steady;
        logic [2:0] pres;
        logic [2:0] stk;
        int         arrivals;
    } seg_t;

    seg_t segs[19];

    initial begin
        int arr_cnt;
        int off_cnt;
        int run_len[3];
        idle_all = {IDLE, IDLE, IDLE};

        segs[0]  = '{3'b000, 1'b1, 15, 1'b0, 3'b000, 3'b000, 0};
        segs[1]  = '{3'b001, 1'b1,  3, 1'b1, 3'b000, 3'b000, 0};
        segs[2]  = '{3'b000, 1'b1,  6, 1'b1, 3'b000, 3'b000, 0};
        segs[3]  = '{3'b100, 1'b1, 20, 1'b0, 3'b100, 3'b000, 1};
        segs[4]  = '{3'b000, 1'b1,  6, 1'b1, 3'b100, 3'b000, 0};
        segs[5]  = '{3'b100, 1'b1, 10, 1'b1, 3'b100, 3'b000, 0};
        segs[6]  = '{3'b000, 1'b1, 12, 1'b1, 3'b100, 3'b000, 0};
        segs[7]  = '{3'b000, 1'b1,  1, 1'b0, 3'b000, 3'b000, 0};
        segs[8]  = '{3'b010, 1'b1,  6, 1'b0, 3'b010, 3'b000, 1};
        segs[9]  = '{3'b010, 1'b1, 49, 1'b1, 3'b010, 3'b000, 0};
        segs[10] = '{3'b010, 1'b1,  1, 1'b0, 3'b010, 3'b010, 0};
        segs[11] = '{3'b010, 1'b1, 20, 1'b1, 3'b010, 3'b010, 0};
        segs[12] = '{3'b000, 1'b1,  2, 1'b1, 3'b010, 3'b010, 0};
        segs[13] = '{3'b000, 1'b1,  1, 1'b0, 3'b010, 3'b000, 0};
        segs[14] = '{3'b000, 1'b0,  1, 1'b0, 3'b000, 3'b000, 0};
        segs[15] = '{3'b111, 1'b0,  5, 1'b1, 3'b000, 3'b000, 0};
        segs[16] = '{3'b111, 1'b1,  3, 1'b1, 3'b000, 3'b000, 0};
        segs[17] = '{3'b111, 1'b1,  1, 1'b0, 3'b111, 3'b000, 3};
        segs[18] = '{3'b111, 1'b1,  2, 1'b1, 3'b111, 3'b000, 0};

        // Reset held with all sensors active, then released.
        model_clear(1'b1);
        reset_n = 1'b0;
        enable  = 1'b1;
        raw     = 3'b111;
        #1;
        check("reset_present", present, 3'b000);
        check("reset_arrive", arrive, 3'b000);
        check("reset_stuck", stuck, 3'b000);
        check("reset_state", ch_state, idle_all);
        for (int i = 0; i < 3; i++) tick();
        reset_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            if (e < DEB + 2) check("rel_present_early", present, 3'b000);
            if (e == DEB + 2) check("rel_arrive", arrive, 3'b111);
            if (e == DEB + 3) check("rel_arrive_width", arrive, 3'b000);
            if (e >= DEB + 2) check("rel_present", present, 3'b111);
        end

        // Directed segment table.
        for (int i = 0; i < 19; i++) begin
            raw = segs[i].raw;
            enable = segs[i].en;
            arr_cnt = 0;
            for (int c = 0; c < segs[i].cycles; c++) begin
                tick();
                arr_cnt += $countones(arrive);
                if (segs[i].steady) begin
                    check($sformatf("seg%0d_present_steady", i), present, segs[i].pres);
                    check($sformatf("seg%0d_stuck_steady", i), stuck, segs[i].stk);
                end
            end
            check($sformatf("seg%0d_present", i), present, segs[i].pres);
            check($sformatf("seg%0d_stuck", i), stuck, segs[i].stk);
            check($sformatf("seg%0d_arrivals", i), arr_cnt, segs[i].arrivals);
        end

        // Asynchronous reset while channels 1/2 are qualifying and channel 0 is present.
        raw = 3'b000;
        for (int i = 0; i < 15; i++) tick();
        raw = 3'b001;
        for (int i = 0; i < 8; i++) tick();
        check("areset_pre_present", present, 3'b001);
        raw = 3'b111;
        for (int i = 0; i < 4; i++) tick();
        #20;
        reset_n = 1'b0;
        model_clear(1'b1);
        #1;
        check("areset_present", present, 3'b000);
        check("areset_arrive", arrive, 3'b000);
        check("areset_state", ch_state, idle_all);
        for (int i = 0; i < 2; i++) tick();
        reset_n = 1'b1;
        arr_cnt = 0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            if (e < DEB + 2) arr_cnt += $countones(arrive);
            if (e == DEB + 2) check("areset_requal_arrive", arrive, 3'b111);
        end
        check("areset_no_early_arrive", arr_cnt, 0);

        // Randomised traffic against the model.
        for (int i = 0; i < 3; i++) run_len[i] = $urandom_range(1, 20);
        off_cnt = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int i = 0; i < 3; i++) begin
                run_len[i]--;
                if (run_len[i] <= 0) begin
                    raw[i] = ~raw[i];
                    run_len[i] = raw[i] ? $urandom_range(1, 70) : $urandom_range(1, 16);
                end
            end
            if (off_cnt > 0) begin
                off_cnt--;
                if (off_cnt == 0) enable = 1'b1;
            end else if ($urandom_range(0, 199) == 0) begin
                enable = 1'b0;
                off_cnt = $urandom_range(1, 6);
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
